stall_control_unit: RTL and testbench
=====================================

Name: stall_control_unit

Overview:
- Central hazard and stall source for the seven-stage pipeline.
- Drives the stall, stall_mem_wb and branch-redirect inputs consumed by the decode->execute pipeline register, and the hold and squash controls for the fetch stages.
- Detects load-use hazards and redirects.
- Tracks outstanding I-cache and D-cache misses with a small FSM.
- Keeps saturating performance counters.

Parameters:
REG_ADDR_WIDTH, 5, register index width
COUNTER_WIDTH, 32, width of each performance counter

Ports:
clock  in  1  pipeline clock
reset  in  1  synchronous, active-low reset
rs1_decode  in  REG_ADDR_WIDTH  source reg 1 of instruction in decode
rs2_decode  in  REG_ADDR_WIDTH  source reg 2 of instruction in decode
rs1_used_decode  in  1  decode instruction reads rs1
rs2_used_decode  in  1  decode instruction reads rs2
rd_execute  in  REG_ADDR_WIDTH  destination in execute
memRead_execute  in  1  execute holds a load
rd_memory1  in  REG_ADDR_WIDTH  destination in memory1
memRead_memory1  in  1  memory1 holds a load
next_PC_select_execute  in  2  PC select of instruction in execute
branch_execute  in  1  branch in execute resolved taken
i_mem_req  in  1  fetch has an I-cache request this cycle
i_mem_ready  in  1  I-cache returns data this cycle
d_mem_req  in  1  memory1 has a load/store request this cycle
d_mem_ready  in  1  D-cache completes this cycle
stall  out  1  hold fetch/decode; decode pipe bubbles when stall & ~stall_mem_wb
stall_mem_wb  out  1  freeze entire pipeline (D-cache miss)
squash_fetch  out  1  one-cycle pulse: discard instruction arriving from I-cache
fsm_state  out  2  debug: 0 RUN, 1 IMEM_WAIT, 2 DMEM_WAIT
load_use_count  out  COUNTER_WIDTH  load-use stall cycles
imem_stall_count  out  COUNTER_WIDTH  I-miss stall cycles
dmem_stall_count  out  COUNTER_WIDTH  D-miss stall cycles
flush_count  out  COUNTER_WIDTH  redirects taken

Behaviour:
- Reset: while reset==0 at a posedge, fsm_state<=RUN, i_pending<=0, squash_pending<=0, all counters<=0.
- Reset: combinational outputs stall, stall_mem_wb, squash_fetch are forced 0 while reset==0.
- Reset asserted mid-miss abandons the miss; there is no residual squash.
- redirect = (nps_e==2'b11) | (nps_e==2'b10) | (nps_e==2'b01 & branch_execute), where nps_e is next_PC_select_execute.
- lu_e = memRead_execute & rd_execute!=0 & ((rs1_used_decode & rs1_decode==rd_execute) | (rs2_used_decode & rs2_decode==rd_execute)).
- lu_m1 is the same expression using the memory1 fields.
- load_use = (lu_e | lu_m1) & ~redirect. A load in execute therefore yields 2 bubbles; a load in memory1 yields 1. Data is forwarded from writeback.
- dmiss = d_mem_req & ~d_mem_ready; imiss = i_mem_req & ~i_mem_ready.
- stall_mem_wb = (state==DMEM_WAIT & ~d_mem_ready) | (state!=DMEM_WAIT & dmiss). Zero-latency, combinational.
- stall = stall_mem_wb | load_use | (state==IMEM_WAIT & ~i_mem_ready) | (state==RUN & imiss).
- FSM, RUN: dmiss -> DMEM_WAIT (set i_pending if imiss); else imiss -> IMEM_WAIT; else stay.
- FSM, IMEM_WAIT: dmiss -> DMEM_WAIT (i_pending<=~i_mem_ready); else i_mem_ready -> RUN.
- FSM, DMEM_WAIT: i_mem_ready clears i_pending. On d_mem_ready: next state is IMEM_WAIT if i_pending (and no i_mem_ready this cycle), else RUN.
- Squash: redirect & ~stall_mem_wb while an I-request is outstanding (IMEM_WAIT, RUN&imiss, or i_pending) sets squash_pending.
- Squash: squash_fetch = squash_pending & i_mem_ready. squash_pending clears the same cycle.
- Squash: a redirect in the same cycle as i_mem_ready asserts squash_fetch directly.
- Counters saturate at all-ones and never wrap.
- load_use_count increments per cycle with load_use & ~stall_mem_wb.
- imem_stall_count increments per cycle stall is asserted due to an I-miss term & ~stall_mem_wb.
- dmem_stall_count increments per cycle with stall_mem_wb.
- flush_count increments per cycle with redirect & ~stall_mem_wb.
- Priority: a D-miss dominates every other term; a redirect masks load_use.

Decomposition:
- Shared pipeline package holds: the state encodings RUN/IMEM_WAIT/DMEM_WAIT, the next_PC_select encodings (00 seq, 01 branch, 10 JAL, 11 JALR), and the NOP constant 32'h00000013.
- One natural sub-module: sat_counter (width param, inc, sync active-low reset), instantiated four times.

Test Plan:
1. Load x5 in execute, decode reads rs1=x5 -> stall=1 for 2 cycles, stall_mem_wb=0, load_use_count=2; the same with rd=x0 gives stall=0.
2. d_mem_req=1, d_mem_ready low 4 cycles -> stall_mem_wb=stall=1 for exactly 4 cycles, fsm_state=2, dmem_stall_count=4, RUN after ready.
3. I-miss 3 cycles with a JAL redirect (nps_e=10) in cycle 1 -> squash_fetch=1 only in the i_mem_ready cycle, flush_count=1.
4. D-miss and I-miss start together; i_mem_ready arrives before d_mem_ready -> stays DMEM_WAIT, then RUN; i_pending cleared, no extra stall cycle.
5. Preload counter to max-1 via long D-miss (COUNTER_WIDTH=4 build) -> dmem_stall_count saturates at 15.
6. Drive reset=0 mid IMEM_WAIT with squash_pending set -> next cycle fsm_state=0, all counters 0, squash_fetch never pulses.

Source files
------------

// File: rtl/stall_control_unit_pkg.sv
// Shared pipeline encodings for the hazard/stall controller: FSM states,
// next-PC select codes and the canonical NOP.
package stall_control_unit_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        IMEM_WAIT = 2'd1,
        DMEM_WAIT = 2'd2
    } fsm_state_t;

    typedef enum logic [1:0] {
        NPC_SEQ    = 2'b00,
        NPC_BRANCH = 2'b01,
        NPC_JAL    = 2'b10,
        NPC_JALR   = 2'b11
    } next_pc_sel_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/stall_control_unit_if.sv
// Cache handshake and pipeline hold/squash controls between the pipeline
// (master) and the stall control unit (slave).
interface stall_control_unit_if;

    logic i_mem_req;
    logic i_mem_ready;
    logic d_mem_req;
    logic d_mem_ready;
    logic stall;
    logic stall_mem_wb;
    logic squash_fetch;

    modport master (
        output i_mem_req, i_mem_ready, d_mem_req, d_mem_ready,
        input  stall, stall_mem_wb, squash_fetch
    );

    modport slave (
        input  i_mem_req, i_mem_ready, d_mem_req, d_mem_ready,
        output stall, stall_mem_wb, squash_fetch
    );

endinterface

// File: rtl/stall_control_unit_sat_counter.sv
// Saturating up-counter with synchronous active-low clear; holds at all-ones.
module sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clock) begin
        if (!reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/stall_control_unit.sv
// Central hazard/stall source: load-use and redirect detection, I/D-cache
// miss tracking FSM, fetch squash control and saturating perf counters.
module stall_control_unit
    import stall_control_unit_pkg::*;
#(
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned COUNTER_WIDTH  = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_decode,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_decode,
    input  logic                      rs1_used_decode,
    input  logic                      rs2_used_decode,
    input  logic [REG_ADDR_WIDTH-1:0] rd_execute,
    input  logic                      memRead_execute,
    input  logic [REG_ADDR_WIDTH-1:0] rd_memory1,
    input  logic                      memRead_memory1,
    input  logic [1:0]                next_PC_select_execute,
    input  logic                      branch_execute,
    stall_control_unit_if.slave       mem,
    output logic [1:0]                fsm_state,
    output logic [COUNTER_WIDTH-1:0]  load_use_count,
    output logic [COUNTER_WIDTH-1:0]  imem_stall_count,
    output logic [COUNTER_WIDTH-1:0]  dmem_stall_count,
    output logic [COUNTER_WIDTH-1:0]  flush_count
);

    fsm_state_t   state, state_n;
    next_pc_sel_t nps_e;
    logic         i_pending, i_pending_n;
    logic         squash_pending, squash_pending_n;
    logic         i_mem_ready, d_mem_ready;
    logic         redirect, lu_e, lu_m1, load_use;
    logic         dmiss, imiss, smw_raw, imem_term, i_outstanding;

    assign i_mem_ready = mem.i_mem_ready;
    assign d_mem_ready = mem.d_mem_ready;
    assign nps_e       = next_pc_sel_t'(next_PC_select_execute);

    assign redirect = (nps_e == NPC_JALR) || (nps_e == NPC_JAL) ||
                      ((nps_e == NPC_BRANCH) && branch_execute);

    assign lu_e  = memRead_execute && (rd_execute != '0) &&
                   ((rs1_used_decode && (rs1_decode == rd_execute)) ||
                    (rs2_used_decode && (rs2_decode == rd_execute)));
    assign lu_m1 = memRead_memory1 && (rd_memory1 != '0) &&
                   ((rs1_used_decode && (rs1_decode == rd_memory1)) ||
                    (rs2_used_decode && (rs2_decode == rd_memory1)));
    assign load_use = (lu_e || lu_m1) && !redirect;

    assign dmiss = mem.d_mem_req && !d_mem_ready;
    assign imiss = mem.i_mem_req && !i_mem_ready;

    // Unqualified by reset; the exported versions below are gated.
    assign smw_raw       = (state == DMEM_WAIT) ? !d_mem_ready : dmiss;
    assign imem_term     = ((state == IMEM_WAIT) && !i_mem_ready) ||
                           ((state == RUN) && imiss);
    assign i_outstanding = (state == IMEM_WAIT) || ((state == RUN) && imiss) ||
                           i_pending;

    assign mem.stall_mem_wb = reset && smw_raw;
    assign mem.stall        = reset && (smw_raw || load_use || imem_term);
    assign mem.squash_fetch = reset && i_mem_ready &&
                              (squash_pending || (redirect && !smw_raw));

    assign fsm_state = state;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state          <= RUN;
            i_pending      <= 1'b0;
            squash_pending <= 1'b0;
        end else begin
            state          <= state_n;
            i_pending      <= i_pending_n;
            squash_pending <= squash_pending_n;
        end
    end

    // i_pending only lives inside DMEM_WAIT; on exit the IMEM_WAIT state carries it.
    always_comb begin
        state_n          = state;
        i_pending_n      = i_pending;
        squash_pending_n = (squash_pending || (redirect && !smw_raw && i_outstanding)) &&
                           !i_mem_ready;
        unique case (state)
            RUN: begin
                if (dmiss) begin
                    state_n     = DMEM_WAIT;
                    i_pending_n = imiss;
                end else if (imiss) begin
                    state_n = IMEM_WAIT;
                end
            end
            IMEM_WAIT: begin
                if (dmiss) begin
                    state_n     = DMEM_WAIT;
                    i_pending_n = !i_mem_ready;
                end else if (i_mem_ready) begin
                    state_n = RUN;
                end
            end
            DMEM_WAIT: begin
                if (i_mem_ready) begin
                    i_pending_n = 1'b0;
                end
                if (d_mem_ready) begin
                    state_n     = (i_pending && !i_mem_ready) ? IMEM_WAIT : RUN;
                    i_pending_n = 1'b0;
                end
            end
            default: begin
                state_n     = RUN;
                i_pending_n = 1'b0;
            end
        endcase
    end

    sat_counter #(.WIDTH(COUNTER_WIDTH)) u_load_use_count (
        .clock (clock),
        .reset (reset),
        .inc   (load_use && !smw_raw),
        .count (load_use_count)
    );

    sat_counter #(.WIDTH(COUNTER_WIDTH)) u_imem_stall_count (
        .clock (clock),
        .reset (reset),
        .inc   (imem_term && !smw_raw),
        .count (imem_stall_count)
    );

    sat_counter #(.WIDTH(COUNTER_WIDTH)) u_dmem_stall_count (
        .clock (clock),
        .reset (reset),
        .inc   (smw_raw),
        .count (dmem_stall_count)
    );

    sat_counter #(.WIDTH(COUNTER_WIDTH)) u_flush_count (
        .clock (clock),
        .reset (reset),
        .inc   (redirect && !smw_raw),
        .count (flush_count)
    );

endmodule

// File: tb/tb_stall_control_unit.sv
// Directed and randomized bench for stall_control_unit, checked every cycle
// against a behavioural model built from miss-outstanding flags.
module tb_stall_control_unit;

    localparam int unsigned RW   = 5;
    localparam int unsigned CW   = 4;
    localparam int          CMAX = (1 << CW) - 1;

    logic clock = 1'b0;
    logic reset;
    logic [RW-1:0] rs1_decode, rs2_decode, rd_execute, rd_memory1;
    logic rs1_used_decode, rs2_used_decode, memRead_execute, memRead_memory1;
    logic [1:0] next_PC_select_execute;
    logic branch_execute;
    logic [1:0] fsm_state;
    logic [CW-1:0] load_use_count, imem_stall_count, dmem_stall_count, flush_count;

    stall_control_unit_if bus ();

    stall_control_unit #(.REG_ADDR_WIDTH(RW), .COUNTER_WIDTH(CW)) dut (
        .clock                  (clock),
        .reset                  (reset),
        .rs1_decode             (rs1_decode),
        .rs2_decode             (rs2_decode),
        .rs1_used_decode        (rs1_used_decode),
        .rs2_used_decode        (rs2_used_decode),
        .rd_execute             (rd_execute),
        .memRead_execute        (memRead_execute),
        .rd_memory1             (rd_memory1),
        .memRead_memory1        (memRead_memory1),
        .next_PC_select_execute (next_PC_select_execute),
        .branch_execute         (branch_execute),
        .mem                    (bus),
        .fsm_state              (fsm_state),
        .load_use_count         (load_use_count),
        .imem_stall_count       (imem_stall_count),
        .dmem_stall_count       (dmem_stall_count),
        .flush_count            (flush_count)
    );

    always #5 clock = ~clock;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    // Model: md = a D-miss is being waited on, mi = an I-miss is being waited on.
    bit md, mi, msq;
    int c_lu, c_im, c_dm, c_fl;
    bit e_stall, e_smw, e_sf, e_redirect, e_lu, e_iterm, e_imiss;
    int e_state;
    logic last_stall, last_smw, last_sf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit reads(input logic [RW-1:0] rd);
        return (rd != 0) && ((rs1_used_decode && rs1_decode == rd) ||
                             (rs2_used_decode && rs2_decode == rd));
    endfunction

    task automatic eval_model();
        bit dmiss;
        e_redirect = (next_PC_select_execute >= 2) ||
                     (next_PC_select_execute == 1 && branch_execute);
        e_lu    = ((memRead_execute && reads(rd_execute)) ||
                   (memRead_memory1 && reads(rd_memory1))) && !e_redirect;
        dmiss   = bus.d_mem_req && !bus.d_mem_ready;
        e_imiss = bus.i_mem_req && !bus.i_mem_ready;
        e_smw   = md ? !bus.d_mem_ready : dmiss;
        e_iterm = !md && (mi ? !bus.i_mem_ready : e_imiss);
        e_stall = e_smw || e_lu || e_iterm;
        e_sf    = bus.i_mem_ready && (msq || (e_redirect && !e_smw));
        if (!reset) begin
            e_stall = 0; e_smw = 0; e_sf = 0;
        end
        e_state = md ? 2 : (mi ? 1 : 0);
    endtask

    function automatic int sat(input int v, input bit inc);
        return (inc && v < CMAX) ? v + 1 : v;
    endfunction

    task automatic advance_model();
        bit dmiss, ir, nmd, nmi, iout;
        if (!reset) begin
            md = 0; mi = 0; msq = 0;
            c_lu = 0; c_im = 0; c_dm = 0; c_fl = 0;
            return;
        end
        ir    = bus.i_mem_ready;
        dmiss = bus.d_mem_req && !bus.d_mem_ready;
        c_lu  = sat(c_lu, e_lu && !e_smw);
        c_im  = sat(c_im, e_iterm && !e_smw);
        c_dm  = sat(c_dm, e_smw);
        c_fl  = sat(c_fl, e_redirect && !e_smw);
        iout  = mi || (!md && e_imiss);
        msq   = (msq || (e_redirect && !e_smw && iout)) && !ir;
        nmd = md; nmi = mi;
        if (md) begin
            nmi = mi && !ir;
            if (bus.d_mem_ready) nmd = 0;
        end else if (dmiss) begin
            nmd = 1;
            nmi = mi ? !ir : e_imiss;
        end else if (mi) begin
            if (ir) nmi = 0;
        end else if (e_imiss) begin
            nmi = 1;
        end
        md = nmd; mi = nmi;
    endtask

    // Inputs are driven at posedge+1; outputs are checked mid-cycle.
    task automatic tick();
        #4;
        eval_model();
        last_stall = bus.stall; last_smw = bus.stall_mem_wb; last_sf = bus.squash_fetch;
        check("stall",        {31'b0, bus.stall},        {31'b0, e_stall});
        check("stall_mem_wb", {31'b0, bus.stall_mem_wb}, {31'b0, e_smw});
        check("squash_fetch", {31'b0, bus.squash_fetch}, {31'b0, e_sf});
        check("fsm_state",    {30'b0, fsm_state},        e_state);
        check("load_use_count",   {28'b0, load_use_count},   c_lu);
        check("imem_stall_count", {28'b0, imem_stall_count}, c_im);
        check("dmem_stall_count", {28'b0, dmem_stall_count}, c_dm);
        check("flush_count",      {28'b0, flush_count},      c_fl);
        advance_model();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        reset = 1'b1;
        rs1_decode = '0; rs2_decode = '0; rd_execute = '0; rd_memory1 = '0;
        rs1_used_decode = 0; rs2_used_decode = 0; memRead_execute = 0; memRead_memory1 = 0;
        next_PC_select_execute = 2'b00; branch_execute = 0;
        bus.i_mem_req = 0; bus.i_mem_ready = 0; bus.d_mem_req = 0; bus.d_mem_ready = 0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    initial begin
        idle();
        md = 0; mi = 0; msq = 0; c_lu = 0; c_im = 0; c_dm = 0; c_fl = 0;
        @(posedge clock);
        #1;
        do_reset();
        check("reset_state", {30'b0, fsm_state}, 0);
        check("reset_lu_cnt", {28'b0, load_use_count}, 0);

        // Load-use: load in execute then memory1 gives two bubbles.
        rd_execute = 5; memRead_execute = 1; rs1_decode = 5; rs1_used_decode = 1;
        tick();
        check("t1_stall_ex", {31'b0, last_stall}, 1);
        rd_execute = 0; memRead_execute = 0; rd_memory1 = 5; memRead_memory1 = 1;
        tick();
        check("t1_stall_m1", {31'b0, last_stall}, 1);
        check("t1_smw", {31'b0, last_smw}, 0);
        idle();
        tick();
        check("t1_lu_count", {28'b0, load_use_count}, 2);
        rd_execute = 0; memRead_execute = 1; rs1_decode = 0; rs1_used_decode = 1;
        tick();
        check("t1_x0_stall", {31'b0, last_stall}, 0);

        // D-miss for four cycles.
        do_reset();
        bus.d_mem_req = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t2_smw", {31'b0, last_smw}, 1);
        end
        check("t2_state", {30'b0, fsm_state}, 2);
        bus.d_mem_ready = 1;
        tick();
        check("t2_smw_done", {31'b0, last_smw}, 0);
        check("t2_state_run", {30'b0, fsm_state}, 0);
        check("t2_dm_count", {28'b0, dmem_stall_count}, 4);
        idle();

        // I-miss with a JAL redirect in the first miss cycle.
        do_reset();
        bus.i_mem_req = 1; next_PC_select_execute = 2'b10;
        tick();
        check("t3_no_sq_early", {31'b0, last_sf}, 0);
        next_PC_select_execute = 2'b00;
        tick();
        tick();
        bus.i_mem_ready = 1;
        tick();
        check("t3_squash", {31'b0, last_sf}, 1);
        idle();
        tick();
        check("t3_no_sq_late", {31'b0, last_sf}, 0);
        check("t3_flush", {28'b0, flush_count}, 1);
        check("t3_im_count", {28'b0, imem_stall_count}, 3);

        // D-miss and I-miss together; I-cache answers first.
        do_reset();
        bus.d_mem_req = 1; bus.i_mem_req = 1;
        tick();
        bus.i_mem_ready = 1;
        tick();
        check("t4_state_dwait", {30'b0, fsm_state}, 2);
        bus.i_mem_ready = 0; bus.i_mem_req = 0; bus.d_mem_ready = 1;
        tick();
        idle();
        tick();
        check("t4_state_run", {30'b0, fsm_state}, 0);
        check("t4_no_stall", {31'b0, last_stall}, 0);
        check("t4_im_count", {28'b0, imem_stall_count}, 0);

        // Long D-miss saturates the narrow counter.
        do_reset();
        bus.d_mem_req = 1;
        for (int i = 0; i < 20; i++) tick();
        check("t5_dm_sat", {28'b0, dmem_stall_count}, 15);
        idle();
        tick();

        // Reset while waiting on an I-miss with a squash pending.
        do_reset();
        bus.i_mem_req = 1; next_PC_select_execute = 2'b11;
        tick();
        next_PC_select_execute = 2'b00;
        tick();
        reset = 0;
        tick();
        check("t6_state", {30'b0, fsm_state}, 0);
        check("t6_flush", {28'b0, flush_count}, 0);
        check("t6_im_count", {28'b0, imem_stall_count}, 0);
        reset = 1; bus.i_mem_ready = 1;
        tick();
        check("t6_no_squash", {31'b0, last_sf}, 0);
        idle();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 63) != 0);
            rs1_decode = RW'($urandom_range(0, 3));
            rs2_decode = RW'($urandom_range(0, 3));
            rd_execute = RW'($urandom_range(0, 3));
            rd_memory1 = RW'($urandom_range(0, 3));
            rs1_used_decode = 1'($urandom);
            rs2_used_decode = 1'($urandom);
            memRead_execute = 1'($urandom);
            memRead_memory1 = 1'($urandom);
            next_PC_select_execute = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            branch_execute = 1'($urandom);
            bus.i_mem_req   = 1'($urandom);
            bus.i_mem_ready = ($urandom_range(0, 2) == 0);
            bus.d_mem_req   = ($urandom_range(0, 3) == 0);
            bus.d_mem_ready = ($urandom_range(0, 2) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
